// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction fetch stage: default widths,
// the reset fetch address and the fetch controller state encoding.
package fetch_stage_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam int unsigned FBUF_DEPTH     = 2;
    localparam int unsigned FBUF_CNT_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_e;

    // Combined request occupancy used to throttle new instruction requests.
    function automatic logic [FBUF_CNT_W-1:0] fetch_occupancy(
        input logic [FBUF_CNT_W-1:0] buf_count,
        input logic                  outstanding
    );
        return buf_count + {{(FBUF_CNT_W-1){1'b0}}, outstanding};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO between instruction memory responses and the decode stage.
// The head entry is presented straight from storage registers.
module fetch_buffer
    import fetch_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 96
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_push_data,
    input  logic                  i_pop,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_head,
    output logic [FBUF_CNT_W-1:0] o_count
);

    logic [WIDTH-1:0]      r_mem [FBUF_DEPTH];
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [FBUF_CNT_W-1:0] r_count;
    logic                  w_do_push;
    logic                  w_do_pop;
    logic [FBUF_CNT_W-1:0] w_count_nxt;

    // Qualify push/pop against full/empty so illegal operations are ignored.
    always_comb begin
        w_do_push = i_push & (r_count != 2'd2);
        w_do_pop  = i_pop  & (r_count != 2'd0);
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage, pointers and occupancy; a flush discards every entry.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < FBUF_DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
        end
    end

    // Head and status presentation.
    always_comb begin
        o_valid = (r_count != 2'd0);
        o_head  = r_mem[r_rd_ptr];
        o_count = r_count;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one request at a time to instruction memory,
// buffers up to two responses for decode, and handles branch redirects.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH = DATA_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC   = DATA_WIDTH'(RESET_PC_DEF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_o
);

    localparam int unsigned          ENTRY_W = 3 * DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(32'd4);

    fetch_state_e          r_state;
    fetch_state_e          w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] w_pc_nxt;
    logic [DATA_WIDTH-1:0] r_req_pc;
    logic [DATA_WIDTH-1:0] w_req_pc_nxt;
    logic [DATA_WIDTH-1:0] w_redirect_pc;

    logic                  w_outstanding;
    logic                  w_req;
    logic                  w_grant;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_buf_valid;
    logic [FBUF_CNT_W-1:0] w_buf_count;
    logic [ENTRY_W-1:0]    w_push_data;
    logic [ENTRY_W-1:0]    w_head;

    // Handshake qualification; a redirect overrides both push and pop.
    always_comb begin
        w_outstanding = (r_state == ST_WAIT) || (r_state == ST_DROP);
        w_req         = (r_state == ST_FETCH) &&
                        (fetch_occupancy(w_buf_count, w_outstanding) < 2'd2);
        w_grant       = w_req & imem_gnt_i;
        w_push        = (r_state == ST_WAIT) & imem_rvalid_i & ~redirect_i;
        w_pop         = w_buf_valid & ready_i & ~redirect_i;
        w_redirect_pc = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
        w_push_data   = {imem_rdata_i, r_req_pc, r_req_pc + PC_STEP};
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. A response arriving together with a redirect already
    // retires the outstanding request, so nothing is left to drop.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect_i) begin
                    w_state_nxt = w_grant ? ST_DROP : ST_FETCH;
                end else if (w_grant) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    w_state_nxt = ST_FETCH;
                end else if (redirect_i) begin
                    w_state_nxt = ST_DROP;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (imem_rvalid_i) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_DROP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Fetch PC and the PC of the request currently in flight.
    always_comb begin
        w_pc_nxt     = r_pc;
        w_req_pc_nxt = r_req_pc;
        if (redirect_i) begin
            w_pc_nxt = w_redirect_pc;
        end else if (w_grant) begin
            w_pc_nxt     = r_pc + PC_STEP;
            w_req_pc_nxt = r_pc;
        end else begin
            w_pc_nxt = r_pc;
        end
    end

    // PC registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else begin
            r_pc     <= w_pc_nxt;
            r_req_pc <= w_req_pc_nxt;
        end
    end

    // Output decode.
    always_comb begin
        imem_req_o                     = w_req;
        imem_addr_o                    = r_pc;
        valid_o                        = w_buf_valid;
        {instr_o, pc_o, pc_plus4_o}    = w_head;
    end

    fetch_buffer #(
        .WIDTH (ENTRY_W)
    ) u_fetch_buffer (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_flush     (redirect_i),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_valid     (w_buf_valid),
        .o_head      (w_head),
        .o_count     (w_buf_count)
    );

endmodule
